// File: rtl/ps2_host_tx_pkg.sv
// Shared definitions for the PS/2 host transmitter: FSM encodings, command bytes, frame builder.
package ps2_host_tx_pkg;

  // FSM state encodings (3-bit, kept as plain constants for legacy compatibility)
  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StInhibit  = 3'd1;
  localparam logic [2:0] StRts      = 3'd2;
  localparam logic [2:0] StShift    = 3'd3;
  localparam logic [2:0] StAck      = 3'd4;
  localparam logic [2:0] StWaitIdle = 3'd5;

  // Common keyboard command / response bytes
  localparam logic [7:0] CmdReset  = 8'hFF;
  localparam logic [7:0] CmdSetLed = 8'hED;
  localparam logic [7:0] CmdEnable = 8'hF4;
  localparam logic [7:0] RspAck    = 8'hFA;

  // {stop, odd parity, data}; shifted out LSB first
  function automatic logic [9:0] build_frame(input logic [7:0] data);
    return {1'b1, ~^data, data};
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// One PS/2 line: 2-FF synchronizer, FilterLen-sample glitch filter and falling-edge detector.
module ps2_line_filter #(
  parameter int unsigned FilterLen = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic line_i,
  output logic sync_o,
  output logic filt_o,
  output logic fall_o
);

  localparam int unsigned CntW = $clog2(FilterLen + 1);

  logic [1:0]      sync_q;
  logic            filt_q, filt_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            fall_q;

  // Filtered level flips only after FilterLen consecutive samples disagree with it
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (sync_q[1] != filt_q) begin
      if (cnt_q == CntW'(FilterLen - 1)) begin
        filt_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Synchronizer, filter state and registered fall pulse; idle bus level is high
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= 2'b11;
      filt_q <= 1'b1;
      cnt_q  <= '0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], line_i};
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
      fall_q <= filt_q & ~filt_d;
    end
  end

  assign sync_o = sync_q[1];
  assign filt_o = filt_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: request-to-send, device-clocked shift-out, line-ack check.
module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter int unsigned ClkFreqHz     = 100_000_000,
  parameter int unsigned InhibitCycles = 10_000,
  parameter int unsigned TimeoutCycles = 1_500_000,
  parameter int unsigned FilterLen     = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic       busy_o,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe_o,
  output logic       ps2_data_oe_o,
  output logic       tx_done_o,
  output logic       tx_err_o
);

  localparam int unsigned InhW = $clog2(InhibitCycles + 1);
  localparam int unsigned TmoW = $clog2(TimeoutCycles + 1);

  logic clk_sync, clk_filt, clk_fall;
  logic data_sync, data_filt, data_fall;

  ps2_line_filter #(.FilterLen(FilterLen)) u_clk_filter (
    .clk    (clk),
    .reset  (reset),
    .line_i (ps2_clk_i),
    .sync_o (clk_sync),
    .filt_o (clk_filt),
    .fall_o (clk_fall)
  );

  ps2_line_filter #(.FilterLen(FilterLen)) u_data_filter (
    .clk    (clk),
    .reset  (reset),
    .line_i (ps2_data_i),
    .sync_o (data_sync),
    .filt_o (data_filt),
    .fall_o (data_fall)
  );

  // Only the synchronized data level and the filtered clock are needed here
  logic unused_sigs;
  assign unused_sigs = ^{clk_sync, data_filt, data_fall, ClkFreqHz};

  logic [2:0]      state_q, state_d;
  logic [9:0]      frame_q, frame_d;
  logic [3:0]      bitcnt_q, bitcnt_d;
  logic [InhW-1:0] inh_q, inh_d;
  logic [TmoW-1:0] tmo_q, tmo_d, tmo_inc;
  logic            clk_oe_q, clk_oe_d;
  logic            data_oe_q, data_oe_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            ready_q, ready_d;
  logic            busy_q, busy_d;
  logic            tmo_active;

  assign tmo_inc    = tmo_q + 1'b1;
  assign tmo_active = state_q inside {StShift, StAck, StWaitIdle};

  // Next-state, frame shifting and line-drive decisions
  always_comb begin
    state_d   = state_q;
    frame_d   = frame_q;
    bitcnt_d  = bitcnt_q;
    inh_d     = inh_q;
    tmo_d     = tmo_q;
    clk_oe_d  = clk_oe_q;
    data_oe_d = data_oe_q;
    done_d    = 1'b0;
    err_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        if (tx_valid_i && ready_q) begin
          frame_d  = build_frame(tx_data_i);
          bitcnt_d = '0;
          inh_d    = '0;
          tmo_d    = '0;
          clk_oe_d = 1'b1;
          state_d  = StInhibit;
        end
      end
      StInhibit: begin
        inh_d = inh_q + 1'b1;
        // Start bit goes out on the last cycle the clock is held low
        if (inh_q == InhW'(InhibitCycles - 2)) begin
          data_oe_d = 1'b1;
          state_d   = StRts;
        end
      end
      StRts: begin
        clk_oe_d = 1'b0;
        tmo_d    = '0;
        state_d  = StShift;
      end
      StShift: begin
        tmo_d = tmo_inc;
        if (clk_fall && (bitcnt_q < 4'd10)) begin
          tmo_d     = '0;
          data_oe_d = ~frame_q[bitcnt_q];
          bitcnt_d  = bitcnt_q + 1'b1;
          if (bitcnt_q == 4'd9) begin
            state_d = StAck;
          end
        end
      end
      StAck: begin
        tmo_d = tmo_inc;
        if (clk_fall) begin
          tmo_d = '0;
          if (!data_sync) begin
            state_d = StWaitIdle;
          end else begin
            err_d     = 1'b1;
            data_oe_d = 1'b0;
            state_d   = StIdle;
          end
        end
      end
      StWaitIdle: begin
        tmo_d = clk_fall ? '0 : tmo_inc;
        if (clk_filt && data_sync) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        state_d   = StIdle;
      end
    endcase

    // Device stalled: abandon the transfer and free both lines at once
    if (tmo_active && !clk_fall && (tmo_inc == TmoW'(TimeoutCycles))) begin
      clk_oe_d  = 1'b0;
      data_oe_d = 1'b0;
      done_d    = 1'b0;
      err_d     = 1'b1;
      state_d   = StIdle;
    end

    // Ready comes back the cycle after a done/err pulse
    ready_d = (state_d == StIdle) && !done_d && !err_d;
    busy_d  = (state_d != StIdle);
  end

  // State and registered outputs; reset releases the bus immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      frame_q   <= '0;
      bitcnt_q  <= '0;
      inh_q     <= '0;
      tmo_q     <= '0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      frame_q   <= frame_d;
      bitcnt_q  <= bitcnt_d;
      inh_q     <= inh_d;
      tmo_q     <= tmo_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      done_q    <= done_d;
      err_q     <= err_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
    end
  end

  assign tx_ready_o    = ready_q;
  assign busy_o        = busy_q;
  assign ps2_clk_oe_o  = clk_oe_q;
  assign ps2_data_oe_o = data_oe_q;
  assign tx_done_o     = done_q;
  assign tx_err_o      = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Scoreboard bench for ps2_host_tx with an open-drain PS/2 device model.
module tb_ps2_host_tx;
  import ps2_host_tx_pkg::*;

  localparam int unsigned Inhibit = 20;
  localparam int unsigned Timeout = 3000;
  localparam int unsigned FiltLen = 4;
  localparam int          Half    = 100;

  localparam int ModeNormal = 0;
  localparam int ModeSilent = 1;
  localparam int ModeNoAck  = 2;
  localparam int ModeStop5  = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready, busy, ps2_clk_oe, ps2_data_oe, tx_done, tx_err;
  logic       dev_clk_low, dev_data_low;
  logic       ps2_clk_pad, ps2_data_pad;

  // Open-drain bus: either side may pull low
  assign ps2_clk_pad  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_pad = ~(ps2_data_oe | dev_data_low);

  always #5 clk = ~clk;

  ps2_host_tx #(
    .ClkFreqHz     (100_000_000),
    .InhibitCycles (Inhibit),
    .TimeoutCycles (Timeout),
    .FilterLen     (FiltLen)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .tx_data_i     (tx_data),
    .tx_valid_i    (tx_valid),
    .tx_ready_o    (tx_ready),
    .busy_o        (busy),
    .ps2_clk_i     (ps2_clk_pad),
    .ps2_data_i    (ps2_data_pad),
    .ps2_clk_oe_o  (ps2_clk_oe),
    .ps2_data_oe_o (ps2_data_oe),
    .tx_done_o     (tx_done),
    .tx_err_o      (tx_err)
  );

  typedef struct {
    logic [7:0] data;
    logic       is_err;
    logic       has_frame;
  } exp_t;

  exp_t       exp_q[$];
  logic [9:0] cap_q[$];
  int         dev_mode = ModeNormal;
  logic       dev_abort = 1'b0;
  int         vectors = 0;
  int         miscompares = 0;

  task automatic check_bit(input string name, input logic act, input logic req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %b, expected %b", name, act, req);
    end
  endtask

  task automatic check_int(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, req, req);
    end
  endtask

  // Reference frame as the device should see it: data LSB first, odd parity, stop
  function automatic logic [9:0] model_frame(input logic [7:0] d);
    logic [9:0] f;
    int ones = 0;
    for (int i = 0; i < 8; i++) begin
      f[i] = d[i];
      if (d[i]) ones++;
    end
    f[8] = (ones % 2 == 0);
    f[9] = 1'b1;
    return f;
  endfunction

  // Monitor: every done/err pulse is matched against the oldest expected outcome
  initial begin : monitor
    exp_t e;
    logic prev_pulse = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (tx_done || tx_err) begin
        check_bit("pulse_exclusive", tx_done & tx_err, 1'b0);
        check_bit("pulse_single_cycle", prev_pulse, 1'b0);
        check_bit("pulse_expected", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check_bit("outcome_err", tx_err, e.is_err);
          check_bit("outcome_done", tx_done, !e.is_err);
          if (e.has_frame) begin
            check_bit("frame_captured", cap_q.size() > 0, 1'b1);
            if (cap_q.size() > 0) check_int("device_frame", int'(cap_q.pop_front()),
                                            int'(model_frame(e.data)));
          end
        end
      end
      prev_pulse = tx_done | tx_err;
    end
  end

  task automatic dev_wait(input int c);
    repeat (c) @(negedge clk);
  endtask

  // Device clocks the frame, sampling data on each rising edge, then clocks the ack bit
  task automatic dev_frame();
    logic [9:0] bits = '0;
    dev_wait(50);
    for (int k = 1; k <= 11; k++) begin
      if (dev_abort) return;
      if (dev_mode == ModeStop5 && k > 5) return;
      if (k == 11) begin
        dev_data_low = (dev_mode != ModeNoAck);
        dev_wait(50);
      end
      dev_clk_low = 1'b1;
      dev_wait(Half);
      dev_clk_low = 1'b0;
      if (k <= 10) bits[k-1] = ps2_data_pad;
      if (k == 10) cap_q.push_back(bits);
      if (k == 11) begin
        dev_wait(20);
        dev_data_low = 1'b0;
      end else begin
        dev_wait(Half);
      end
    end
  endtask

  initial begin : device
    int n;
    dev_clk_low  = 1'b0;
    dev_data_low = 1'b0;
    forever begin
      @(negedge clk);
      if (ps2_clk_oe && !dev_abort) begin
        n = 0;
        while (ps2_clk_oe && n < 1000) begin
          @(negedge clk);
          n++;
        end
        check_bit("rts_released", n < 1000, 1'b1);
        check_bit("start_bit_at_release", ps2_data_oe, 1'b1);
        if (dev_mode != ModeSilent) dev_frame();
        dev_clk_low  = 1'b0;
        dev_data_low = 1'b0;
        while (dev_abort) @(negedge clk);
      end
    end
  end

  task automatic send(input logic [7:0] d, input int mode);
    exp_t e;
    int n = 0;
    while (!tx_ready && n < 6000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_bit("ready_before_send", tx_ready, 1'b1);
    @(negedge clk);
    dev_mode    = mode;
    tx_data     = d;
    tx_valid    = 1'b1;
    e.data      = d;
    e.is_err    = (mode != ModeNormal);
    e.has_frame = (mode == ModeNormal) || (mode == ModeNoAck);
    exp_q.push_back(e);
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || !tx_ready) && n < 8000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_int("drain_pending", exp_q.size(), 0);
    exp_q.delete();
    repeat (150) @(posedge clk);
  endtask

  initial begin : watchdog
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int low_cnt, data_rise, clk_fall, viol, n, t, r;
    logic seen_high;
    reset    = 1'b1;
    tx_valid = 1'b0;
    tx_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    check_bit("reset_tx_ready", tx_ready, 1'b1);
    check_bit("reset_busy", busy, 1'b0);
    check_bit("reset_clk_oe", ps2_clk_oe, 1'b0);
    check_bit("reset_data_oe", ps2_data_oe, 1'b0);
    check_bit("reset_tx_done", tx_done, 1'b0);
    check_bit("reset_tx_err", tx_err, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // Directed commands, then random bytes
    send(CmdSetLed, ModeNormal); drain();
    send(CmdEnable, ModeNormal); drain();
    send(8'h00, ModeNormal);     drain();
    repeat (5) begin
      send(8'($urandom_range(0, 255)), ModeNormal);
      drain();
    end
    send(8'($urandom_range(0, 255)), ModeNoAck); drain();

    // tx_valid held high: exact request-to-send timing and no second accept
    @(negedge clk);
    begin
      exp_t e;
      e.data = CmdReset; e.is_err = 1'b0; e.has_frame = 1'b1;
      exp_q.push_back(e);
    end
    dev_mode = ModeNormal;
    tx_data  = CmdReset;
    tx_valid = 1'b1;
    low_cnt = 0; data_rise = -1; clk_fall = -1; viol = 0;
    @(posedge clk);
    #1;
    for (int j = 1; j <= 30; j++) begin
      if (clk_fall < 0) begin
        if (ps2_clk_oe) low_cnt++;
        else clk_fall = j;
      end
      if (ps2_data_oe && data_rise < 0) data_rise = j;
      if (tx_ready) viol++;
      if (j < 30) begin
        @(posedge clk);
        #1;
      end
    end
    check_int("inhibit_length", low_cnt, int'(Inhibit));
    check_int("data_oe_rise_cycle", data_rise, int'(Inhibit));
    check_int("clk_oe_fall_cycle", clk_fall, int'(Inhibit) + 1);
    n = 0;
    while (!(tx_done || tx_err) && n < 6000) begin
      @(posedge clk);
      #1;
      if (!(tx_done || tx_err) && tx_ready) viol++;
      n++;
    end
    tx_valid = 1'b0;
    check_bit("held_valid_pulse_seen", tx_done, 1'b1);
    check_bit("ready_low_in_pulse", tx_ready, 1'b0);
    check_int("ready_while_busy", viol, 0);
    @(posedge clk);
    #1;
    check_bit("ready_after_pulse", tx_ready, 1'b1);
    drain();

    // Device never clocks: error exactly Timeout cycles after RTS release
    send(CmdEnable, ModeSilent);
    t = 0; r = -1; seen_high = 1'b0;
    while (!(tx_done || tx_err) && t < 6000) begin
      @(posedge clk);
      #1;
      t++;
      if (seen_high && !ps2_clk_oe && r < 0) r = t;
      seen_high = seen_high | ps2_clk_oe;
    end
    check_int("timeout_latency", t - r, int'(Timeout));
    check_bit("timeout_clk_oe", ps2_clk_oe, 1'b0);
    check_bit("timeout_data_oe", ps2_data_oe, 1'b0);
    @(posedge clk);
    #1;
    check_bit("timeout_ready", tx_ready, 1'b1);
    drain();

    // Missing ack, and a device that stalls after 5 bits
    send(CmdSetLed, ModeNoAck); drain();
    send(8'hA5, ModeStop5);     drain();
    check_bit("stall_clk_oe", ps2_clk_oe, 1'b0);
    check_bit("stall_data_oe", ps2_data_oe, 1'b0);

    // Asynchronous reset in the middle of shifting
    send(8'h00, ModeNormal);
    repeat (600) @(posedge clk);
    #1;
    check_bit("busy_before_reset", busy, 1'b1);
    check_bit("data_oe_before_reset", ps2_data_oe, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check_bit("reset_mid_clk_oe", ps2_clk_oe, 1'b0);
    check_bit("reset_mid_data_oe", ps2_data_oe, 1'b0);
    check_bit("reset_mid_ready", tx_ready, 1'b1);
    check_bit("reset_mid_busy", busy, 1'b0);
    exp_q.delete();
    dev_abort = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (300) @(negedge clk);
    cap_q.delete();
    dev_abort = 1'b0;
    send(CmdReset, ModeNormal); drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
